// File: rtl/seg7_pkg.sv
// Shared types, constants and glyph table for the seven-segment scan driver.
// Segment vectors are active-low and ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t       SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

  // Entry 15 first: F, E, d, C, b, A, 9 .. 0.
  localparam seg_t [15:0] GLYPH_TABLE = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex-to-seven-segment decoder (active-low cathodes).
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] value_i,
  output seg_t       seg_o
);

  assign seg_o = GLYPH_TABLE[value_i];

endmodule

// File: rtl/seg7_scan.sv
// Four-digit multiplexed common-anode display driver with per-slot blanking gap.
// Optional leading-zero suppression is enabled by defining SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  input  logic [3:0] digit2,
  input  logic [3:0] digit3,
  input  logic [3:0] dp_mask,
  output logic [3:0] an,
  output seg_t       seg,
  output logic       dp
);

  localparam int unsigned CntW = $clog2(REFRESH_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [3:0]      snap_q [4];
  logic [3:0]      snap_dp_q;
  logic            wrap, capture, blank, lit;
  logic [3:0]      cur_digit;
  seg_t            cur_seg;
  logic [3:0]      an_d;
  seg_t            seg_d;
  logic            dp_d;

  // Prescaler and slot index
  always_comb begin
    wrap    = (cnt_q == CntMax);
    cnt_d   = wrap ? '0 : cnt_q + 1'b1;
    idx_d   = wrap ? idx_q + 2'd1 : idx_q;
    capture = (idx_q == 2'd0) && (cnt_q == '0);
    blank   = (32'(cnt_q) < BLANK_CYCLES);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      idx_q <= 2'd0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  // Whole-frame snapshot keeps a displayed frame coherent.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap_q    <= '{default: 4'h0};
      snap_dp_q <= 4'h0;
    end else if (capture) begin
      snap_q    <= '{digit0, digit1, digit2, digit3};
      snap_dp_q <= dp_mask;
    end
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic [3:0] supp_q, supp_d;

  // A digit is suppressed only when it and every higher digit are zero.
  always_comb begin
    supp_d    = 4'h0;
    supp_d[3] = (digit3 == 4'h0);
    supp_d[2] = supp_d[3] && (digit2 == 4'h0);
    supp_d[1] = supp_d[2] && (digit1 == 4'h0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      supp_q <= 4'h0;
    end else if (capture) begin
      supp_q <= supp_d;
    end
  end

  assign lit = !blank && !supp_q[idx_q];
`else
  assign lit = !blank;
`endif

  assign cur_digit = snap_q[idx_q];

  seg7_decode u_decode (
    .value_i (cur_digit),
    .seg_o   (cur_seg)
  );

  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    if (lit) begin
      an_d         = AN_OFF;
      an_d[idx_q]  = 1'b0;
      seg_d        = cur_seg;
      dp_d         = ~snap_dp_q[idx_q];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      an  <= AN_OFF;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= an_d;
      seg <= seg_d;
      dp  <= dp_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Directed self-checking bench for seg7_scan with REFRESH_DIV=8, BLANK_CYCLES=2.
module tb_seg7_scan;

  logic       clk;
  logic       reset_n;
  logic [3:0] digit0, digit1, digit2, digit3;
  logic [3:0] dp_mask;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int checks;
  int failures;
  int cyc;

  // Bench-side view of what the display should hold for the current frame.
  logic [3:0] exp_snap [4];
  logic [3:0] exp_dp;
  logic [3:0] exp_supp;

  seg7_scan #(
    .REFRESH_DIV  (8),
    .BLANK_CYCLES (2)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .digit0  (digit0),
    .digit1  (digit1),
    .digit2  (digit2),
    .digit3  (digit3),
    .dp_mask (dp_mask),
    .an      (an),
    .seg     (seg),
    .dp      (dp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;
      4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;
      default: glyph = 7'b0001110;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_an"}, {3'b000, an}, 7'h0F);
    chk({tag, "_seg"}, seg, 7'h7F);
    chk({tag, "_dp"}, {6'b0, dp}, 7'h01);
  endtask

  // Advance n clock edges, checking every output against the slot model.
  task automatic run(input int n);
    int         p;
    int         s;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      cyc++;
      p = (cyc - 1) % 8;
      s = ((cyc - 1) / 8) % 4;
      if ((cyc - 1) % 32 == 0) begin
        exp_snap = '{digit0, digit1, digit2, digit3};
        exp_dp   = dp_mask;
        exp_supp = 4'h0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        exp_supp[3] = (digit3 == 4'h0);
        exp_supp[2] = exp_supp[3] && (digit2 == 4'h0);
        exp_supp[1] = exp_supp[2] && (digit1 == 4'h0);
`endif
      end
      e_an  = 4'hF;
      e_seg = 7'h7F;
      e_dp  = 1'b1;
      if (p >= 2 && !exp_supp[s]) begin
        e_an[s] = 1'b0;
        e_seg   = glyph(exp_snap[s]);
        e_dp    = ~exp_dp[s];
      end
      chk("an", {3'b000, an}, {3'b000, e_an});
      chk("seg", seg, e_seg);
      chk("dp", {6'b0, dp}, {6'b0, e_dp});
      chk("one_hot_an", {6'b0, ($countones(~an) <= 1)}, 7'h01);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    exp_snap = '{default: 4'h0};
    exp_dp   = 4'h0;
    exp_supp = 4'h0;

    // Reset held with digits 4,3,2,1 (digit3..0)
    reset_n = 1'b0;
    digit0 = 4'h1; digit1 = 4'h2; digit2 = 4'h3; digit3 = 4'h4;
    dp_mask = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");

    reset_n = 1'b1;
    cyc = 0;
    run(3);
    chk("first_lit_an", {3'b000, an}, 7'b0001110);
    chk("first_lit_seg", seg, 7'b1111001);
    run(29);

    // Hex glyph, DP on digit 2, then a mid-frame change that must wait a frame
    digit2 = 4'h5; digit1 = 4'hA; dp_mask = 4'b0100;
    run(10);
    digit2 = 4'h7; digit1 = 4'h0; dp_mask = 4'b0000;
    run(22);
    run(32);

    // Leading zeros, then all zeros
    digit3 = 4'h0; digit2 = 4'h0; digit1 = 4'h3; digit0 = 4'h7;
    run(32);
    digit1 = 4'h0; digit0 = 4'h0;
    run(32);

    // Async reset during the active phase of slot 2
    digit0 = 4'h1; digit1 = 4'h2; digit2 = 4'h3; digit3 = 4'h4;
    dp_mask = 4'b0100;
    run(20);
    chk("slot2_an", {3'b000, an}, 7'b0001011);
    chk("slot2_dp", {6'b0, dp}, 7'h00);
    #3;
    reset_n = 1'b0;
    #1;
    chk_reset_vals("async_reset");
    digit0 = 4'h5; digit1 = 4'h6; digit2 = 4'h8; digit3 = 4'h9;
    dp_mask = 4'b0001;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_reset_vals("reset_hold");
    reset_n = 1'b1;
    cyc = 0;
    exp_supp = 4'h0;
    run(32);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg7_scan.md
# seg7_scan

Four-digit multiplexed seven-segment display driver. It consumes the four BCD digits (`digit0` least significant … `digit3`) produced by the stopwatch timer and drives a common-anode display: active-low anodes plus active-low segment cathodes. It sits between the timer and the board display pins. It scans one digit at a time and inserts a blanking gap at every digit change to suppress ghosting. All four digits are sampled together once per frame, so a displayed frame is always coherent.

## Interface
Parameters:
- `REFRESH_DIV`, default 100000: clock cycles per digit slot. Must be ≥ 2.
- `BLANK_CYCLES`, default 1000: cycles at the start of each slot with all anodes off. Range 1 … `REFRESH_DIV`-1.

Ports:
- `clk`, input, 1: system clock.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `digit0`..`digit3`, input, 4 each: digit values. `digit0` is the rightmost digit.
- `dp_mask`, input, 4: decimal point enable per digit. Bit i lights the DP on digit i.
- `an`, output, 4: anodes, active-low. Bit i selects digit i.
- `seg`, output, 7: cathodes, active-low, ordered {g,f,e,d,c,b,a}.
- `dp`, output, 1: decimal point cathode, active-low.

## Operation
- Prescaler `cnt` counts 0 … `REFRESH_DIV`-1 and then wraps to 0.
- Slot index `idx` is 2 bits. It increments when `cnt` wraps, and goes 3 → 0.
- Snapshot registers `snap[0..3]` and `snap_dp` capture `digit0..3` and `dp_mask` on the cycle where `idx`==0 and `cnt`==0. This includes the first cycle after reset release.
- Blank phase is `cnt` < `BLANK_CYCLES`:
  - `an`=4'b1111, `seg`=7'h7F, `dp`=1.
- Active phase (all other cycles):
  - `an`=~(1<<`idx`).
  - `seg`=decode(`snap[idx]`).
  - `dp`=~`snap_dp[idx]`.
- Decode uses standard patterns for 0–9 and hex glyphs A, b, C, d, E, F for 10–15. Examples: 0 → 7'b1000000, 8 → 7'b0000000, 1 → 7'b1111001.
- Input changes mid-frame have no effect until the next capture.

## Timing
- Reset values: `an`=4'b1111, `seg`=7'h7F, `dp`=1, `cnt`=0, `idx`=0, `snap`=0, `snap_dp`=0.
- `an`, `seg` and `dp` are registered. Their value in cycle t+1 is computed from the `cnt`, `idx` and `snap` held in cycle t.
- Latency from capture to first lit display is `BLANK_CYCLES`+1 cycles.
- Slot period is `REFRESH_DIV` cycles. Frame period is 4×`REFRESH_DIV` cycles.
- On any digit change, at most one anode is low, and never two in consecutive cycles without an intervening blank phase.
- Snapshot load and the outputs never conflict: capture happens at `cnt`==0, which is always inside the blank phase.
- Reset asserted mid-slot: every output goes immediately (asynchronously) to its reset value. After release, scanning restarts at `idx`=0 and `cnt`=0 with a fresh capture.

## Configuration
- Macro `SEG7_LEADING_ZERO_BLANK_EN`.
- Defined: when captured, digit i (i = 3, 2, 1) is suppressed if it and every higher digit equal 0.
  - A suppressed slot stays in blank output for its whole duration. Its anode stays high and its DP is not lit.
  - `digit0` is never suppressed.
  - The suppression flags are captured together with `snap`.
- Undefined: all four digits are always displayed, including leading zeros.

## Structure
- Package `seg7_pkg` contains:
  - typedef `seg_t` (logic [6:0]).
  - constants `SEG_BLANK`=7'h7F and `AN_OFF`=4'hF.
  - the 16-entry glyph table.
- Sub-module `seg7_decode`: combinational, 4-bit value in, `seg_t` out.
- The top level holds the prescaler, slot index, snapshot registers and output registers.

## Test plan
All scenarios use `REFRESH_DIV`=8 and `BLANK_CYCLES`=2.
- **Reset:** hold `reset_n`=0 → `an`=4'b1111, `seg`=7'h7F, `dp`=1. Release with digits 4,3,2,1 (digit3..0) → from cycle 3 `an`=4'b1110 and `seg`=decode(1)=7'b1111001. Check 8-cycle slots and 32-cycle frames.
- **Blank gap:** across every slot boundary, `an`=4'b1111 for exactly 2 cycles. Never more than one anode low in any cycle.
- **Coherency:** change `digit2` from 5 to 7 mid-frame → `seg` in the `idx`=2 slot stays decode(5) until the next frame, then shows decode(7).
- **Decimal point and hex:** `dp_mask`=4'b0100, `digit1`=4'hA → `dp`=0 only in the digit-2 active phase. The digit-1 slot shows 7'b0001000.
- **Leading-zero blank:** digits 0,0,3,7 (digit3..0) with `SEG7_LEADING_ZERO_BLANK_EN`:
  - defined → the digit-3 and digit-2 slots keep `an`=4'b1111.
  - undefined → both show decode(0).
  - all zeros → only `digit0` is lit, showing 0.
- **Async reset mid-slot:** assert `reset_n`=0 during the active phase of slot 2 → outputs return to reset values in the same cycle. After release, scanning resumes at slot 0.
